// File: rtl/syscall_ctrl.sv
// syscall_ctrl: sequences SYSCALL execution in the 5-stage MIPS pipeline.
// On a SYSCALL in ID the front end is stalled, older instructions drain for
// DRAIN_CYCLES cycles, $v0/$a0 are sampled, and the service is dispatched
// (print int, print char, exit, or unknown). Print output goes to the console
// sink through a valid/ready handshake.
// Optional build macro: SYSCALL_STATS_EN adds stat_cycles/stat_syscalls counters.
module syscall_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        syscall_vld,
    input  logic [31:0] v0,
    input  logic [31:0] a0,
    input  logic        out_ready,
    output logic        stall,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic        out_char,
    output logic        halt,
    output logic        err_unknown
`ifdef SYSCALL_STATS_EN
    ,
    output logic [31:0] stat_cycles,
    output logic [31:0] stat_syscalls
`endif
);

    localparam logic [3:0]  LP_DRAIN       = 4'(DRAIN_CYCLES);
    localparam bit          LP_NO_DRAIN    = (DRAIN_CYCLES == 0);
    localparam logic [31:0] SVC_PRINT_INT  = 32'd1;
    localparam logic [31:0] SVC_EXIT       = 32'd10;
    localparam logic [31:0] SVC_PRINT_CHAR = 32'd11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAIN,
        S_DISPATCH,
        S_PRINT,
        S_RELEASE,
        S_HALT
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;
    logic [31:0] r_v0_q;
    logic [31:0] r_a0_q;
    logic        r_out_valid;
    logic [31:0] r_out_data;
    logic        r_out_char;
    logic        r_halt;
    logic        r_err_unknown;
    logic        w_accept;
    logic        w_capture;
    logic        w_transfer;

    // Qualifying events shared by the FSM and the datapath
    always_comb begin
        w_accept   = (r_state == S_IDLE) && syscall_vld;
        // With no drain window the operands are sampled on the accepting edge itself
        w_capture  = (w_accept && LP_NO_DRAIN) ||
                     ((r_state == S_DRAIN) && (r_cnt == 4'd1));
        w_transfer = (r_state == S_PRINT) && r_out_valid && out_ready;
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (syscall_vld) begin
                    w_next = LP_NO_DRAIN ? S_DISPATCH : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (r_cnt == 4'd1) begin
                    w_next = S_DISPATCH;
                end
            end
            S_DISPATCH: begin
                if ((r_v0_q == SVC_PRINT_INT) || (r_v0_q == SVC_PRINT_CHAR)) begin
                    w_next = S_PRINT;
                end else if (r_v0_q == SVC_EXIT) begin
                    w_next = S_HALT;
                end else begin
                    w_next = S_RELEASE;
                end
            end
            S_PRINT: begin
                if (w_transfer) begin
                    w_next = S_RELEASE;
                end
            end
            S_RELEASE: w_next = S_IDLE;
            S_HALT:    w_next = S_HALT;
            default:   w_next = S_IDLE;
        endcase
    end

    // Stall output: follows syscall_vld in IDLE, drops only in RELEASE, forced low in reset
    always_comb begin
        stall = 1'b0;
        if (!reset) begin
            case (r_state)
                S_IDLE:    stall = syscall_vld;
                S_RELEASE: stall = 1'b0;
                default:   stall = 1'b1;
            endcase
        end
    end

    // Drain counter and operand capture
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt  <= '0;
            r_v0_q <= '0;
            r_a0_q <= '0;
        end else begin
            if (w_accept) begin
                r_cnt <= LP_DRAIN;
            end else if (r_state == S_DRAIN) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_capture) begin
                r_v0_q <= v0;
                r_a0_q <= a0;
            end
        end
    end

    // Registered service outputs: set on the DISPATCH edge, valid cleared on transfer
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid   <= 1'b0;
            r_out_data    <= '0;
            r_out_char    <= 1'b0;
            r_halt        <= 1'b0;
            r_err_unknown <= 1'b0;
        end else begin
            r_err_unknown <= 1'b0;
            if (r_state == S_DISPATCH) begin
                if (r_v0_q == SVC_PRINT_INT) begin
                    r_out_data  <= r_a0_q;
                    r_out_char  <= 1'b0;
                    r_out_valid <= 1'b1;
                end else if (r_v0_q == SVC_PRINT_CHAR) begin
                    r_out_data  <= {24'b0, r_a0_q[7:0]};
                    r_out_char  <= 1'b1;
                    r_out_valid <= 1'b1;
                end else if (r_v0_q == SVC_EXIT) begin
                    r_halt <= 1'b1;
                end else begin
                    r_err_unknown <= 1'b1;
                end
            end else if (w_transfer) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    // Drive ports from their registers
    always_comb begin
        out_valid   = r_out_valid;
        out_data    = r_out_data;
        out_char    = r_out_char;
        halt        = r_halt;
        err_unknown = r_err_unknown;
    end

`ifdef SYSCALL_STATS_EN
    logic [31:0] r_stat_cycles;
    logic [31:0] r_stat_syscalls;

    // Cycle counter freezes once halted; syscall counter steps once per DISPATCH cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stat_cycles   <= '0;
            r_stat_syscalls <= '0;
        end else begin
            if (!r_halt) begin
                r_stat_cycles <= r_stat_cycles + 32'd1;
            end
            if (r_state == S_DISPATCH) begin
                r_stat_syscalls <= r_stat_syscalls + 32'd1;
            end
        end
    end

    // Expose counters
    always_comb begin
        stat_cycles   = r_stat_cycles;
        stat_syscalls = r_stat_syscalls;
    end

`ifndef SYNTHESIS
    // Report counters when the program exits
    always_ff @(posedge clk) begin
        if (!reset && (r_state == S_DISPATCH) && (w_next == S_HALT)) begin
            $display("syscall_ctrl: exit, cycles=%0d syscalls=%0d",
                     r_stat_cycles, r_stat_syscalls + 32'd1);
        end
    end
`endif
`endif

endmodule
